bcd_stopwatch_timer: RTL

Parametrised multi-digit BCD time counter: the next generation of the lab stopwatch counter. It counts up as a stopwatch or down as a preloadable countdown timer, at a tick rate divided from the system clock. It adds a lap-hold display snapshot, terminal-count and overflow pulses, and a wrap/saturate option. It sits between the button/control FSM and the seven-segment display driver, and `time_reading` feeds the display mux directly.

---
 rtl/bcd_stopwatch_timer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_timer.sv
// Multi-digit BCD stopwatch / countdown timer with a clock-derived tick, a lap-hold snapshot view,
// terminal-count (done) and overflow pulses, and a wrap-or-saturate option at all-9s.
module bcd_stopwatch_timer #(
  parameter int CLK_FREQ = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                init_regs_n,
  input  logic                count_enabled,
  input  logic                mode,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                lap,
  output logic [4*DIGITS-1:0] time_reading,
  output logic                done,
  output logic                overflow,
  output logic                holding
);

  localparam int W = 4 * DIGITS;
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } view_t;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!c) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!b) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [DW-1:0] div_r, div_s;
  logic [W-1:0]  digits_r, digits_s;
  logic [W-1:0]  snap_r, snap_s;
  view_t         view_r, view_s;
  logic          lap_q_r;
  logic          sat_r, sat_s;
  logic          tick_s, lap_rise_s, done_s, ovf_s;

  // Next-state: load preempts everything; the lap snapshot takes the pre-tick digits.
  always_comb begin
    div_s      = div_r;
    digits_s   = digits_r;
    snap_s     = snap_r;
    view_s     = view_r;
    sat_s      = sat_r;
    tick_s     = 1'b0;
    done_s     = 1'b0;
    ovf_s      = 1'b0;
    lap_rise_s = lap & ~lap_q_r;

    if (load) begin
      digits_s = bcd_clamp(load_value);
      div_s    = '0;
      view_s   = LIVE;
      sat_s    = 1'b0;
    end else begin
      case (view_r)
        LIVE: begin
          if (lap_rise_s) begin
            view_s = HOLD;
            snap_s = digits_r;
          end else begin
            view_s = LIVE;
          end
        end
        HOLD: begin
          if (lap_rise_s) begin
            view_s = LIVE;
          end else begin
            view_s = HOLD;
          end
        end
        default: view_s = LIVE;
      endcase

      // An exhausted countdown parks the divider so restarting begins a full period.
      if (mode && (digits_r == '0)) begin
        div_s = '0;
      end else if (count_enabled) begin
        if (div_r == DIV_LAST) begin
          div_s  = '0;
          tick_s = 1'b1;
        end else begin
          div_s = div_r + DW'(1);
        end
      end else begin
        div_s = div_r;
      end

      if (!tick_s) begin
        digits_s = digits_r;
      end else if (!mode) begin
        if (digits_r != ALL_NINES) begin
          digits_s = bcd_inc(digits_r);
        end else if (WRAP) begin
          digits_s = '0;
          ovf_s    = 1'b1;
        end else begin
          // Saturated: report only the first tick that runs into the limit.
          digits_s = digits_r;
          ovf_s    = ~sat_r;
          sat_s    = 1'b1;
        end
      end else begin
        digits_s = bcd_dec(digits_r);
        done_s   = (bcd_dec(digits_r) == '0);
        sat_s    = 1'b0;
      end
    end
  end

  // State and output registers; outputs are driven from next-state so pulses align with the value.
  always_ff @(posedge clk) begin
    if (!init_regs_n) begin
      div_r        <= '0;
      digits_r     <= '0;
      snap_r       <= '0;
      view_r       <= LIVE;
      lap_q_r      <= 1'b0;
      sat_r        <= 1'b0;
      time_reading <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      holding      <= 1'b0;
    end else begin
      div_r        <= div_s;
      digits_r     <= digits_s;
      snap_r       <= snap_s;
      view_r       <= view_s;
      lap_q_r      <= lap;
      sat_r        <= sat_s;
      time_reading <= (view_s == HOLD) ? snap_s : digits_s;
      done         <= done_s;
      overflow     <= ovf_s;
      holding      <= (view_s == HOLD);
    end
  end

endmodule
